// File: rtl/shift_register_piso_stream.sv
// Parallel-in serial-out shift register with a valid/ready load handshake.
// A word is shifted out LANES bits per beat. last_o flags the final beat.
// A new word can load on the same edge that consumes the final beat, so
// frames can stream back to back with no idle cycle between them.
module shift_register_piso_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          COVER     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] value_i,
  input  logic             advance_i,
  output logic [LANES-1:0] bits_o,
  output logic             bits_valid_o,
  output logic             last_o
);

  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Refuse to build a configuration where the lanes do not tile the word.
  if ((LANES == 0) || (WIDTH % LANES != 0)) begin : g_bad_lanes
    $error("shift_register_piso_stream: LANES must divide WIDTH exactly");
  end

  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;   // beats remaining; zero means idle
  logic             load_accept;
  logic             beat_taken;

  // Handshake and status, all decoded straight from the beat counter.
  // The advance_i -> load_ready_o path lets a new word replace the last beat.
  assign bits_valid_o = (count != '0);
  assign last_o       = (count == ONE_C);
  assign load_ready_o = (count == '0) | ((count == ONE_C) & advance_i);
  assign load_accept  = load_valid_i & load_ready_o;
  assign beat_taken   = advance_i & (count != '0);

  // Present the lane at the output end of the data register.
  if (MSB_FIRST) begin : g_msb_out
    assign bits_o = data[WIDTH-1 -: LANES];
  end else begin : g_lsb_out
    assign bits_o = data[LANES-1:0];
  end

  // Counter and datapath: reset, then load, then shift, otherwise hold.
  // Zero fill on each shift leaves data all-zero once the frame drains.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      // NOTE: the data register is reset too (it is a register, not a memory),
      // so bits_o reads zero after reset and no aborted frame survives.
      data  <= '0;
      count <= '0;
    end else if (load_accept) begin
      data  <= value_i;
      count <= BEATS_C;
    end else if (beat_taken) begin
      data  <= MSB_FIRST ? (data << LANES) : (data >> LANES);
      count <= count - ONE_C;
    end
  end

`ifdef FORMAL
  localparam bit FV_ON = 1'b1;
`else
  localparam bit FV_ON = COVER;
`endif

  if (FV_ON) begin : g_fv
    // Safety properties on the counter and the handshake.
    a_idle_after_reset : assert property (@(posedge clk_i) rst_i |=> !bits_valid_o);
    a_count_bound      : assert property (@(posedge clk_i) count <= BEATS_C);
    a_no_ready_mid     : assert property (@(posedge clk_i) (count > ONE_C) |-> !load_ready_o);

    if ((WIDTH == 8) && (LANES == 1)) begin : g_cover_b2b
      // Two 0xA5 frames, the second loaded on the final beat of the first.
      c_b2b_a5 : cover property (@(posedge clk_i) disable iff (rst_i)
        (load_accept && (value_i == 8'hA5) && (count == '0))
        ##1 (load_accept && (value_i == 8'hA5) && (count == ONE_C))[->1]);
    end
  end

endmodule
